// File: rtl/ram_ufm_write_back_if.sv
// rtl/ram_ufm_write_back_if.sv - shadow RAM read port and UFM Avalon-MM write port bundle
interface ram_ufm_write_back_if #(
    parameter int addr_bits = 9
);
    logic [addr_bits-1:0] ram_addr_o;
    logic                 ram_read_enable_o;
    logic [31:0]          ram_data_i;
    logic [addr_bits-1:0] ufm_addr_o;
    logic [31:0]          ufm_data_o;
    logic                 ufm_write_o;
    logic                 ufm_wait_req_i;
    logic [1:0]           ufm_burst_count_o;
    logic [3:0]           ufm_byte_enable_o;

    modport master (
        output ram_addr_o, ram_read_enable_o,
        input  ram_data_i,
        output ufm_addr_o, ufm_data_o, ufm_write_o, ufm_burst_count_o, ufm_byte_enable_o,
        input  ufm_wait_req_i
    );

    modport slave (
        input  ram_addr_o, ram_read_enable_o,
        output ram_data_i,
        input  ufm_addr_o, ufm_data_o, ufm_write_o, ufm_burst_count_o, ufm_byte_enable_o,
        output ufm_wait_req_i
    );
endinterface

// File: rtl/ram_ufm_write_back.sv
// rtl/ram_ufm_write_back.sv - copies shadow RAM words back into the UFM data port
module ram_ufm_write_back #(
    parameter int num_words   = 512,
    parameter int ram_latency = 1,
    parameter int skip_blank  = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_i,
    ram_ufm_write_back_if.master        bus,
    output logic                        busy_o,
    output logic                        complete_o,
    output logic [$clog2(num_words):0]  prog_count_o
);
    localparam int num_addr_bits = $clog2(num_words);
    localparam logic [num_addr_bits-1:0] last_word = num_addr_bits'(num_words - 1);
    localparam logic [num_addr_bits:0]   max_count = (num_addr_bits + 1)'(num_words);
    localparam logic [1:0]               lat_load  = 2'(ram_latency - 1);

    typedef enum logic [2:0] {
        IDLE, RAM_RD, RAM_WAIT, CHECK, WRITE, NEXT, DONE
    } state_t;

    state_t                   state, state_nxt;
    logic [num_addr_bits-1:0] wordcount;
    logic [num_addr_bits:0]   prog_count;
    logic [31:0]              data_q;
    logic [1:0]               lat_cnt;
    logic                     complete;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (start_i) state_nxt = RAM_RD;
            RAM_RD:   state_nxt = RAM_WAIT;
            RAM_WAIT: if (lat_cnt == 2'd0) state_nxt = CHECK;
            CHECK:    state_nxt = (skip_blank != 0 && data_q == 32'hFFFF_FFFF) ? NEXT : WRITE;
            WRITE:    if (!bus.ufm_wait_req_i) state_nxt = NEXT;
            NEXT:     state_nxt = (wordcount == last_word) ? DONE : RAM_RD;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Strobes decode straight from the state register so a reset drops them at once
    always_comb begin
        bus.ram_read_enable_o = (state == RAM_RD);
        bus.ufm_write_o       = (state == WRITE);
        busy_o                = (state != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wordcount  <= '0;
            prog_count <= '0;
            data_q     <= '0;
            lat_cnt    <= '0;
            complete   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    wordcount  <= '0;
                    prog_count <= '0;
                    complete   <= 1'b0;
                end
                RAM_RD: lat_cnt <= lat_load;
                RAM_WAIT: begin
                    if (lat_cnt == 2'd0) data_q  <= bus.ram_data_i;
                    else                 lat_cnt <= lat_cnt - 2'd1;
                end
                WRITE: if (!bus.ufm_wait_req_i && prog_count != max_count)
                    prog_count <= prog_count + 1'b1;
                NEXT: if (wordcount != last_word) wordcount <= wordcount + 1'b1;
                DONE: complete <= 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.ram_addr_o        = wordcount;
    assign bus.ufm_addr_o        = wordcount;
    assign bus.ufm_data_o        = data_q;
    assign bus.ufm_burst_count_o = 2'd1;
    assign bus.ufm_byte_enable_o = 4'hF;
    assign complete_o            = complete;
    assign prog_count_o          = prog_count;
endmodule

// File: tb/tb_ram_ufm_write_back.sv
// tb/tb_ram_ufm_write_back.sv - directed bench: dut A (lat 1, skip blanks), dut B (lat 3, no skip)
module tb_ram_ufm_write_back;
    logic clk = 1'b0;
    logic rst_a = 1'b1, rst_b = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0;
    logic wait_a = 1'b0;
    logic busy_a, complete_a, busy_b, complete_b;
    logic [3:0] prog_a, prog_b;
    int cyc = 0;
    int tests = 0;
    int fails = 0;

    logic [31:0] mem [8];
    logic [31:0] pipe_a;
    logic [31:0] pipe_b [3];

    int          n_xfer [2];
    int          wr_cycles [2];
    int          stab_err [2];
    int          overlap [2];
    bit          hold [2];
    logic [2:0]  ha [2];
    logic [31:0] hd [2];
    logic [2:0]  xa [2][16];
    logic [31:0] xd [2][16];

    ram_ufm_write_back_if #(.addr_bits(3)) bus_a ();
    ram_ufm_write_back_if #(.addr_bits(3)) bus_b ();

    ram_ufm_write_back #(.num_words(8), .ram_latency(1), .skip_blank(1)) dut_a (
        .clk(clk), .reset(rst_a), .start_i(start_a), .bus(bus_a.master),
        .busy_o(busy_a), .complete_o(complete_a), .prog_count_o(prog_a)
    );

    ram_ufm_write_back #(.num_words(8), .ram_latency(3), .skip_blank(0)) dut_b (
        .clk(clk), .reset(rst_b), .start_i(start_b), .bus(bus_b.master),
        .busy_o(busy_b), .complete_o(complete_b), .prog_count_o(prog_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM models return garbage outside the exact latency slot
    always @(posedge clk) begin
        pipe_a    <= bus_a.ram_read_enable_o ? mem[bus_a.ram_addr_o] : 32'hDEAD_BEEF;
        pipe_b[0] <= bus_b.ram_read_enable_o ? mem[bus_b.ram_addr_o] : 32'hDEAD_BEEF;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign bus_a.ram_data_i     = pipe_a;
    assign bus_b.ram_data_i     = pipe_b[2];
    assign bus_a.ufm_wait_req_i = wait_a;
    assign bus_b.ufm_wait_req_i = 1'b0;

    task automatic mon_sample(input int s, input logic wr, input logic wt, input logic re,
                              input logic [2:0] a, input logic [31:0] d);
        if (wr && re) overlap[s]++;
        if (wr) begin
            wr_cycles[s]++;
            if (!hold[s]) begin
                hold[s] = 1'b1; ha[s] = a; hd[s] = d;
            end else if (a !== ha[s] || d !== hd[s]) begin
                stab_err[s]++;
            end
            if (!wt) begin
                hold[s] = 1'b0;
                if (n_xfer[s] < 16) begin
                    xa[s][n_xfer[s]] = a;
                    xd[s][n_xfer[s]] = d;
                end
                n_xfer[s]++;
            end
        end else begin
            hold[s] = 1'b0;
        end
    endtask

    always begin
        @(negedge clk);
        #1;
        mon_sample(0, bus_a.ufm_write_o, bus_a.ufm_wait_req_i, bus_a.ram_read_enable_o,
                   bus_a.ufm_addr_o, bus_a.ufm_data_o);
        mon_sample(1, bus_b.ufm_write_o, bus_b.ufm_wait_req_i, bus_b.ram_read_enable_o,
                   bus_b.ufm_addr_o, bus_b.ufm_data_o);
    end

    task automatic clr_mon(input int s);
        n_xfer[s] = 0; wr_cycles[s] = 0; stab_err[s] = 0; overlap[s] = 0; hold[s] = 1'b0;
    endtask

    task automatic fill_mem(input bit blanks);
        for (int i = 0; i < 8; i++) mem[i] = 32'h1000_0000 + 32'(i);
        if (blanks) begin
            mem[3] = 32'hFFFF_FFFF;
            mem[5] = 32'hFFFF_FFFF;
        end
    endtask

    task automatic start_pulse(input int s, output int t0);
        @(posedge clk); #1;
        if (s == 0) start_a = 1'b1; else start_b = 1'b1;
        t0 = cyc + 1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input int s, input int t0, output int elapsed);
        bit done = 1'b0;
        elapsed = -1;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (((s == 0) ? complete_a : complete_b) === 1'b1) begin
                done = 1'b1;
                elapsed = cyc - t0;
            end
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL wait_done[%0d]: complete_o not seen, required within 400 cycles", s);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_a_event(input bit on_write, input logic [2:0] a);
        bit hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (on_write) hit = bus_a.ufm_write_o && bus_a.ufm_addr_o == a;
            else          hit = bus_a.ram_read_enable_o && bus_a.ram_addr_o == a;
        end
        tests++;
        if (!hit) begin
            fails++;
            $display("FAIL wait_event: %s at word %0d not seen within 200 cycles",
                     on_write ? "write" : "ram read", a);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        tests += 7;
        if (bus_a.ufm_write_o !== 1'b0) begin fails++; $display("FAIL reset_write: got %b required 0", bus_a.ufm_write_o); end
        if (bus_a.ram_read_enable_o !== 1'b0) begin fails++; $display("FAIL reset_ram_re: got %b required 0", bus_a.ram_read_enable_o); end
        if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b required 0", busy_a); end
        if (complete_a !== 1'b0) begin fails++; $display("FAIL reset_complete: got %b required 0", complete_a); end
        if (prog_a !== 4'd0) begin fails++; $display("FAIL reset_prog: got %0d required 0", prog_a); end
        if (bus_a.ufm_burst_count_o !== 2'd1) begin fails++; $display("FAIL reset_burst: got %0d required 1", bus_a.ufm_burst_count_o); end
        if (bus_a.ufm_byte_enable_o !== 4'hF) begin fails++; $display("FAIL reset_byte_en: got %h required f", bus_a.ufm_byte_enable_o); end
        @(posedge clk); #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
    endtask

    task automatic test_basic;
        int t0, el;
        fill_mem(1'b0);
        clr_mon(0);
        start_pulse(0, t0);
        wait_done(0, t0, el);
        tests += 5;
        if (n_xfer[0] != 8) begin fails++; $display("FAIL basic_count: got %0d required 8", n_xfer[0]); end
        if (el != 41) begin fails++; $display("FAIL basic_latency: got %0d required 41", el); end
        if (prog_a !== 4'd8) begin fails++; $display("FAIL basic_prog: got %0d required 8", prog_a); end
        if (overlap[0] != 0) begin fails++; $display("FAIL basic_overlap: got %0d required 0", overlap[0]); end
        if (wr_cycles[0] != 8) begin fails++; $display("FAIL basic_write_cycles: got %0d required 8", wr_cycles[0]); end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (xa[0][i] !== 3'(i) || xd[0][i] !== 32'h1000_0000 + 32'(i)) begin
                fails++;
                $display("FAIL basic_xfer%0d: got addr %0d data %h required addr %0d data %h",
                         i, xa[0][i], xd[0][i], i, 32'h1000_0000 + 32'(i));
            end
        end
    endtask

    task automatic test_wait_states;
        int t0, el;
        fill_mem(1'b0);
        clr_mon(0);
        start_pulse(0, t0);
        wait_a_event(1'b0, 3'd2);
        wait_a = 1'b1;
        wait_a_event(1'b1, 3'd2);
        repeat (3) @(negedge clk);
        wait_a = 1'b0;
        wait_done(0, t0, el);
        tests += 5;
        if (n_xfer[0] != 8) begin fails++; $display("FAIL wait_count: got %0d required 8", n_xfer[0]); end
        if (wr_cycles[0] != 11) begin fails++; $display("FAIL wait_write_cycles: got %0d required 11", wr_cycles[0]); end
        if (stab_err[0] != 0) begin fails++; $display("FAIL wait_stable: got %0d changes required 0", stab_err[0]); end
        if (el != 44) begin fails++; $display("FAIL wait_latency: got %0d required 44", el); end
        if (xa[0][2] !== 3'd2 || xd[0][2] !== 32'h1000_0002) begin
            fails++; $display("FAIL wait_word2: got addr %0d data %h required 2 10000002", xa[0][2], xd[0][2]);
        end
    endtask

    task automatic test_skip_blank;
        int t0, el;
        int ea[6] = '{0, 1, 2, 4, 6, 7};
        fill_mem(1'b1);
        clr_mon(0);
        start_pulse(0, t0);
        wait_done(0, t0, el);
        tests += 3;
        if (n_xfer[0] != 6) begin fails++; $display("FAIL skip_count: got %0d required 6", n_xfer[0]); end
        if (prog_a !== 4'd6) begin fails++; $display("FAIL skip_prog: got %0d required 6", prog_a); end
        if (el != 39) begin fails++; $display("FAIL skip_latency: got %0d required 39", el); end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (xa[0][i] !== 3'(ea[i]) || xd[0][i] !== 32'h1000_0000 + 32'(ea[i])) begin
                fails++;
                $display("FAIL skip_xfer%0d: got addr %0d data %h required addr %0d", i, xa[0][i], xd[0][i], ea[i]);
            end
        end
        clr_mon(1);
        start_pulse(1, t0);
        wait_done(1, t0, el);
        tests += 3;
        if (n_xfer[1] != 8) begin fails++; $display("FAIL noskip_count: got %0d required 8", n_xfer[1]); end
        if (prog_b !== 4'd8) begin fails++; $display("FAIL noskip_prog: got %0d required 8", prog_b); end
        if (xa[1][5] !== 3'd5 || xd[1][5] !== 32'hFFFF_FFFF) begin
            fails++; $display("FAIL noskip_word5: got addr %0d data %h required 5 ffffffff", xa[1][5], xd[1][5]);
        end
    endtask

    task automatic test_reset_mid_write;
        int t0, el;
        fill_mem(1'b0);
        clr_mon(0);
        start_pulse(0, t0);
        wait_a_event(1'b1, 3'd4);
        #1 rst_a = 1'b1;
        #1;
        tests += 4;
        if (bus_a.ufm_write_o !== 1'b0) begin fails++; $display("FAIL midrst_write: got %b required 0", bus_a.ufm_write_o); end
        if (busy_a !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b required 0", busy_a); end
        if (complete_a !== 1'b0) begin fails++; $display("FAIL midrst_complete: got %b required 0", complete_a); end
        if (prog_a !== 4'd0) begin fails++; $display("FAIL midrst_prog: got %0d required 0", prog_a); end
        @(posedge clk); #1;
        rst_a = 1'b0;
        clr_mon(0);
        start_pulse(0, t0);
        wait_done(0, t0, el);
        tests += 2;
        if (n_xfer[0] != 8) begin fails++; $display("FAIL midrst_rerun_count: got %0d required 8", n_xfer[0]); end
        if (xa[0][0] !== 3'd0 || xa[0][7] !== 3'd7) begin
            fails++; $display("FAIL midrst_rerun_addr: got first %0d last %0d required 0 7", xa[0][0], xa[0][7]);
        end
    endtask

    task automatic test_back_to_back;
        int t0, el;
        fill_mem(1'b0);
        clr_mon(0);
        start_pulse(0, t0);
        wait_a_event(1'b0, 3'd2);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(0, t0, el);
        tests += 3;
        if (n_xfer[0] != 8) begin fails++; $display("FAIL busy_start_count: got %0d required 8", n_xfer[0]); end
        if (el != 41) begin fails++; $display("FAIL busy_start_latency: got %0d required 41", el); end
        if (xa[0][3] !== 3'd3 || xd[0][3] !== 32'h1000_0003) begin
            fails++; $display("FAIL busy_start_word3: got addr %0d data %h required 3 10000003", xa[0][3], xd[0][3]);
        end
        clr_mon(0);
        start_pulse(0, t0);
        tests += 2;
        if (complete_a !== 1'b0) begin fails++; $display("FAIL restart_complete: got %b required 0", complete_a); end
        if (busy_a !== 1'b1) begin fails++; $display("FAIL restart_busy: got %b required 1", busy_a); end
        wait_done(0, t0, el);
        tests += 2;
        if (n_xfer[0] != 8) begin fails++; $display("FAIL restart_count: got %0d required 8", n_xfer[0]); end
        if (el != 41) begin fails++; $display("FAIL restart_latency: got %0d required 41", el); end
    endtask

    task automatic test_latency3;
        int t0, el;
        fill_mem(1'b0);
        clr_mon(1);
        start_pulse(1, t0);
        wait_done(1, t0, el);
        tests += 2;
        if (n_xfer[1] != 8) begin fails++; $display("FAIL lat3_count: got %0d required 8", n_xfer[1]); end
        if (el != 57) begin fails++; $display("FAIL lat3_latency: got %0d required 57", el); end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (xa[1][i] !== 3'(i) || xd[1][i] !== 32'h1000_0000 + 32'(i)) begin
                fails++;
                $display("FAIL lat3_xfer%0d: got addr %0d data %h required addr %0d data %h",
                         i, xa[1][i], xd[1][i], i, 32'h1000_0000 + 32'(i));
            end
        end
    endtask

    initial begin
        clr_mon(0);
        clr_mon(1);
        fill_mem(1'b0);
        test_reset;
        test_basic;
        test_wait_states;
        test_skip_blank;
        test_reset_mid_write;
        test_back_to_back;
        test_latency3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
